// File: rtl/nios_switch_poller.sv
// nios_switch_poller: polls bit 0 of a switch PIO slave over Avalon-MM and debounces it.
module nios_switch_poller #(
  parameter int POLL_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        sw_level,
  output logic        sw_change,
  output logic [15:0] sample_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  localparam logic [15:0] DIV_LOAD = 16'(POLL_DIV - 1);
  localparam logic [7:0]  DEB      = 8'(DEBOUNCE_CNT);
  state_t      state, state_nx;
  logic [15:0] div, div_nx;
  logic [7:0]  stab, stab_nx;
  logic        cand, cand_nx;
  logic        accept;
  logic        sample;
  logic        unused_bits;
  assign sample      = avm_readdata[0];
  assign unused_bits = ^avm_readdata[31:1];
  assign avm_address = 2'b00;
  assign avm_read    = state == REQ;
  always_comb begin
    state_nx = state;
    div_nx   = div;
    stab_nx  = stab;
    cand_nx  = cand;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (!enable) div_nx = DIV_LOAD;
        else if (div == 16'd0) begin
          state_nx = REQ;
          div_nx   = DIV_LOAD;
        end else div_nx = div - 16'd1;
      end
      REQ: state_nx = avm_waitrequest ? REQ : DATA;
      DATA: begin
        state_nx = IDLE;
        if (sample == sw_level) stab_nx = 8'd0;
        else if (sample == cand) stab_nx = stab + 8'd1;
        else begin
          cand_nx = sample;
          stab_nx = 8'd1;
        end
        // the run count is consumed by the acceptance that it triggers
        accept = stab_nx == DEB;
        if (accept) stab_nx = 8'd0;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      div        <= DIV_LOAD;
      stab       <= 8'd0;
      cand       <= 1'b0;
      sw_level   <= 1'b0;
      sw_change  <= 1'b0;
      sample_cnt <= 16'd0;
    end else begin
      state     <= state_nx;
      div       <= div_nx;
      stab      <= stab_nx;
      cand      <= cand_nx;
      sw_change <= accept;
      if (accept) sw_level <= cand_nx;
      if (state == DATA) sample_cnt <= sample_cnt + 16'd1;
    end
  end
endmodule

// File: doc/nios_switch_poller.md
NIOS_SWITCH_POLLER -- requirements
Module: nios_switch_poller

Interface
REQ-001 Parameter POLL_DIV, default 1000: idle cycles between read requests; legal range 2..65535.
REQ-002 Parameter DEBOUNCE_CNT, default 4: consecutive equal differing samples needed to accept a new level; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  polling enable; level-sensitive.
REQ-006 avm_address  output  2  Avalon-MM master address; constant 0 (data register of the switch PIO slave).
REQ-007 avm_read  output  1  Avalon-MM read strobe.
REQ-008 avm_waitrequest  input  1  slave stall; tie to 0 for the fixed-latency PIO slave.
REQ-009 avm_readdata  input  32  slave read data; only bit 0 is used.
REQ-010 sw_level  output  1  debounced switch level, registered.
REQ-011 sw_change  output  1  one-cycle pulse when sw_level changes.
REQ-012 sample_cnt  output  16  count of completed reads, wraps modulo 2^16.

Function
REQ-013 The FSM SHALL have states IDLE, REQ and DATA; all outputs SHALL be registered or decoded from state only.
REQ-014 IDLE behaviour:
- interval counter loads POLL_DIV-1 on entry and decrements each cycle while enable=1;
- when the counter reaches 0 with enable=1, the next state is REQ;
- while enable=0, the counter is held at POLL_DIV-1.
REQ-015 REQ behaviour:
- avm_read=1 and avm_address=0;
- if avm_waitrequest=1, remain in REQ with avm_read held at 1;
- if avm_waitrequest=0, the read is accepted and the next state is DATA.
REQ-016 Read latency SHALL be fixed at 1: in DATA, avm_read=0 and avm_readdata[0] is captured as the sample; the next state is IDLE.
REQ-017 With avm_waitrequest=0 and enable=1, read strobes SHALL occur exactly every POLL_DIV+2 cycles.
REQ-018 Debounce SHALL use a candidate bit and an 8-bit stable counter, evaluated in DATA only:
- sample == sw_level: stable counter cleared;
- sample != sw_level and sample == candidate: stable counter +1;
- sample != sw_level and sample != candidate: candidate <= sample and stable counter <= 1.
REQ-019 When the stable counter value after the DATA update equals DEBOUNCE_CNT:
- sw_level <= candidate;
- sw_change = 1 for the following cycle only;
- stable counter cleared.
REQ-020 With DEBOUNCE_CNT=1, a single differing sample SHALL update sw_level.
REQ-021 sample_cnt SHALL increment by 1 on every DATA cycle and wrap 0xFFFF -> 0x0000 without side effect.
REQ-022 If enable falls during REQ or DATA, the transaction SHALL complete normally (read held until accepted, data captured), then the FSM returns to IDLE and waits.
REQ-023 If enable rises in IDLE, the first read SHALL be issued POLL_DIV cycles later.
REQ-024 sw_change SHALL never be asserted in two consecutive cycles.

Reset
REQ-025 While reset_n=0, the block SHALL set:
- state = IDLE, interval counter = POLL_DIV-1;
- avm_read=0, avm_address=0;
- sw_level=0, candidate=0, stable counter=0;
- sw_change=0, sample_cnt=0.
REQ-026 Reset asserted mid-REQ SHALL drop avm_read immediately (asynchronously); no partial sample is retained after release.
REQ-027 After reset release with enable=1, the first avm_read SHALL assert in cycle POLL_DIV, where cycle 0 is the first clock edge after release.

Verification (POLL_DIV=4, DEBOUNCE_CNT=3, slave model registers bit 0 one cycle after read)
REQ-028 Periodic read: enable=1, waitrequest=0 -> avm_read pulses one cycle every 6 cycles, first at cycle 4; sample_cnt=3 after the third DATA.
REQ-029 Debounce accept: switch 0->1 held -> sw_level=1 and sw_change pulses once, one cycle after the third sample reading 1.
REQ-030 Glitch reject: switch reads 1,1,0,1,1 -> sw_level stays 0 until the sample sequence ends; then 1,1,1 -> sw_level=1.
REQ-031 Waitrequest: waitrequest=1 for 5 cycles during REQ -> avm_read held 5+1 cycles, address stable at 0, one capture, period lengthened by 5.
REQ-032 Enable drop mid-read: enable=0 in REQ with waitrequest=1 -> read completes, then no further avm_read; re-enable -> next read POLL_DIV cycles later.
REQ-033 Reset mid-operation: reset_n=0 during DATA with sw_level=1 -> all outputs 0 at once; after release, first read at cycle 4.
